// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Pipeline execute stage. Operand forwarding muxes, a 32-bit
//               ALU, destination select, and the EX/MEM pipeline register
//               with reset > flush > stall > load priority.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  ID_EX_wb,
  input  logic [1:0]  ID_EX_m,
  input  logic [5:0]  ID_EX_ex,
  input  logic [31:0] ID_EX_readData1,
  input  logic [31:0] ID_EX_readData2,
  input  logic [31:0] ID_EX_imm,
  input  logic [4:0]  ID_EX_rt,
  input  logic [4:0]  ID_EX_rd,
  input  logic [1:0]  ForwardA,
  input  logic [1:0]  ForwardB,
  input  logic [31:0] MEM_WB_writeData,
  output logic        EX_MEM_regWrite,
  output logic        EX_MEM_memToReg,
  output logic [1:0]  EX_MEM_m,
  output logic [31:0] EX_MEM_aluResult,
  output logic [31:0] EX_MEM_writeData,
  output logic [4:0]  EX_MEM_rd,
  output logic        EX_MEM_zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic        w_reg_dst;
  logic        w_alu_src;
  logic [3:0]  w_alu_op;
  logic [31:0] w_op_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_res;
  logic [4:0]  w_dest;

  logic        regWrite_q, regWrite_d;
  logic        memToReg_q, memToReg_d;
  logic [1:0]  m_q, m_d;
  logic [31:0] aluResult_q, aluResult_d;
  logic [31:0] writeData_q, writeData_d;
  logic [4:0]  rd_q, rd_d;
  logic        zero_q, zero_d;

  assign w_reg_dst = ID_EX_ex[5];
  assign w_alu_src = ID_EX_ex[4];
  assign w_alu_op  = ID_EX_ex[3:0];

  // Forwarding muxes; the EX/MEM source is the registered output, so a
  // stalled register naturally forwards its held value.
  always_comb begin
    w_op_a = ID_EX_readData1;
    case (ForwardA)
      2'b10:   w_op_a = aluResult_q;
      2'b01:   w_op_a = MEM_WB_writeData;
      default: w_op_a = ID_EX_readData1;
    endcase
    w_fwd_b = ID_EX_readData2;
    case (ForwardB)
      2'b10:   w_fwd_b = aluResult_q;
      2'b01:   w_fwd_b = MEM_WB_writeData;
      default: w_fwd_b = ID_EX_readData2;
    endcase
  end

  assign w_alu_b = w_alu_src ? ID_EX_imm : w_fwd_b;

  // ALU; add/sub wrap modulo 2^32, SLT uses a true signed compare so an
  // overflowing difference cannot flip the result.
  always_comb begin
    w_alu_res = 32'd0;
    case (w_alu_op)
      OP_AND:  w_alu_res = w_op_a & w_alu_b;
      OP_OR:   w_alu_res = w_op_a | w_alu_b;
      OP_ADD:  w_alu_res = w_op_a + w_alu_b;
      OP_XOR:  w_alu_res = w_op_a ^ w_alu_b;
      OP_SUB:  w_alu_res = w_op_a - w_alu_b;
      OP_SLT:  w_alu_res = {31'd0, ($signed(w_op_a) < $signed(w_alu_b))};
      OP_SLL:  w_alu_res = w_op_a << w_alu_b[4:0];
      OP_SRL:  w_alu_res = w_op_a >> w_alu_b[4:0];
      OP_NOR:  w_alu_res = ~(w_op_a | w_alu_b);
      default: w_alu_res = 32'd0;
    endcase
  end

  assign w_dest = w_reg_dst ? ID_EX_rd : ID_EX_rt;

  // Next-load values; writes to register 0 are suppressed here.
  always_comb begin
    regWrite_d  = ID_EX_wb[1] & (w_dest != 5'd0);
    memToReg_d  = ID_EX_wb[0];
    m_d         = ID_EX_m;
    aluResult_d = w_alu_res;
    writeData_d = w_fwd_b;
    rd_d        = w_dest;
    zero_d      = (w_alu_res == 32'd0);
  end

  // EX/MEM register: reset, then flush (bubble), then stall (hold), then load.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      regWrite_q  <= 1'b0;
      memToReg_q  <= 1'b0;
      m_q         <= 2'b00;
      aluResult_q <= 32'd0;
      writeData_q <= 32'd0;
      rd_q        <= 5'd0;
      zero_q      <= 1'b0;
    end else if (!stall) begin
      regWrite_q  <= regWrite_d;
      memToReg_q  <= memToReg_d;
      m_q         <= m_d;
      aluResult_q <= aluResult_d;
      writeData_q <= writeData_d;
      rd_q        <= rd_d;
      zero_q      <= zero_d;
    end
  end

  assign EX_MEM_regWrite  = regWrite_q;
  assign EX_MEM_memToReg  = memToReg_q;
  assign EX_MEM_m         = m_q;
  assign EX_MEM_aluResult = aluResult_q;
  assign EX_MEM_writeData = writeData_q;
  assign EX_MEM_rd        = rd_q;
  assign EX_MEM_zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage: table of directed vectors
//               plus hand sequences for reset, stall, flush corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [1:0]  ID_EX_wb, ID_EX_m, ForwardA, ForwardB;
  logic [5:0]  ID_EX_ex;
  logic [31:0] ID_EX_readData1, ID_EX_readData2, ID_EX_imm, MEM_WB_writeData;
  logic [4:0]  ID_EX_rt, ID_EX_rd;
  logic        EX_MEM_regWrite, EX_MEM_memToReg, EX_MEM_zero;
  logic [1:0]  EX_MEM_m;
  logic [31:0] EX_MEM_aluResult, EX_MEM_writeData;
  logic [4:0]  EX_MEM_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ID_EX_wb(ID_EX_wb), .ID_EX_m(ID_EX_m), .ID_EX_ex(ID_EX_ex),
    .ID_EX_readData1(ID_EX_readData1), .ID_EX_readData2(ID_EX_readData2),
    .ID_EX_imm(ID_EX_imm), .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .MEM_WB_writeData(MEM_WB_writeData),
    .EX_MEM_regWrite(EX_MEM_regWrite), .EX_MEM_memToReg(EX_MEM_memToReg),
    .EX_MEM_m(EX_MEM_m), .EX_MEM_aluResult(EX_MEM_aluResult),
    .EX_MEM_writeData(EX_MEM_writeData), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_zero(EX_MEM_zero)
  );

  // Expected-output word layout: {regWrite, memToReg, m[1:0], alu[31:0], wdata[31:0], rd[4:0], zero}
  typedef struct {
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [5:0]  ex;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] mwb;
    logic [73:0] exp;
  } vec_t;

  function automatic vec_t mk(logic [1:0] wb, logic [1:0] m, logic [5:0] ex,
                              logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                              logic [4:0] rt, logic [4:0] rd, logic [1:0] fa,
                              logic [1:0] fb, logic [31:0] mwb,
                              logic e_rw, logic e_mtr, logic [1:0] e_m,
                              logic [31:0] e_alu, logic [31:0] e_wd,
                              logic [4:0] e_rd, logic e_z);
    vec_t v;
    v.wb = wb; v.m = m; v.ex = ex; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
    v.rt = rt; v.rd = rd; v.fa = fa; v.fb = fb; v.mwb = mwb;
    v.exp = {e_rw, e_mtr, e_m, e_alu, e_wd, e_rd, e_z};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ID_EX_wb = v.wb; ID_EX_m = v.m; ID_EX_ex = v.ex;
    ID_EX_readData1 = v.rd1; ID_EX_readData2 = v.rd2; ID_EX_imm = v.imm;
    ID_EX_rt = v.rt; ID_EX_rd = v.rd; ForwardA = v.fa; ForwardB = v.fb;
    MEM_WB_writeData = v.mwb;
  endtask

  task automatic chk(input string nm, input logic [73:0] exp);
    logic [73:0] got;
    got = {EX_MEM_regWrite, EX_MEM_memToReg, EX_MEM_m, EX_MEM_aluResult,
           EX_MEM_writeData, EX_MEM_rd, EX_MEM_zero};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got rw=%b mtr=%b m=%b alu=%h wd=%h rd=%0d z=%b, want rw=%b mtr=%b m=%b alu=%h wd=%h rd=%0d z=%b",
               nm, got[73], got[72], got[71:70], got[69:38], got[37:6], got[5:1], got[0],
               exp[73], exp[72], exp[71:70], exp[69:38], exp[37:6], exp[5:1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];
  vec_t rel;
  logic [73:0] held;

  initial begin
    vecs[0]  = mk(2'b10, 2'b00, 6'b100010, 32'd5, 32'd7, 32'd0, 5'd4, 5'd3, 2'b00, 2'b00, 32'd0,
                  1, 0, 2'b00, 32'd12, 32'd7, 5'd3, 0);
    vecs[1]  = mk(2'b00, 2'b01, 6'b010010, 32'd99, 32'd0, 32'd1, 5'd5, 5'd6, 2'b10, 2'b01, 32'd40,
                  0, 0, 2'b01, 32'd13, 32'd40, 5'd5, 0);
    vecs[2]  = mk(2'b11, 2'b10, 6'b100110, 32'h8000_0000, 32'd1, 32'd0, 5'd4, 5'd7, 2'b00, 2'b00, 32'd0,
                  1, 1, 2'b10, 32'h7FFF_FFFF, 32'd1, 5'd7, 0);
    vecs[3]  = mk(2'b10, 2'b00, 6'b100111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 5'd4, 5'd8, 2'b00, 2'b00, 32'd0,
                  1, 0, 2'b00, 32'd1, 32'h7FFF_FFFF, 5'd8, 0);
    vecs[4]  = mk(2'b10, 2'b00, 6'b100110, 32'd5, 32'd5, 32'd0, 5'd4, 5'd9, 2'b00, 2'b00, 32'd0,
                  1, 0, 2'b00, 32'd0, 32'd5, 5'd9, 1);
    vecs[5]  = mk(2'b10, 2'b00, 6'b101111, 32'd3, 32'd4, 32'd0, 5'd4, 5'd9, 2'b00, 2'b00, 32'd0,
                  1, 0, 2'b00, 32'd0, 32'd4, 5'd9, 1);
    vecs[6]  = mk(2'b10, 2'b00, 6'b100010, 32'd1, 32'd2, 32'd0, 5'd4, 5'd0, 2'b00, 2'b00, 32'd0,
                  0, 0, 2'b00, 32'd3, 32'd2, 5'd0, 0);
    vecs[7]  = mk(2'b10, 2'b00, 6'b100000, 32'hF0F0, 32'hFF00, 32'd0, 5'd4, 5'd10, 2'b00, 2'b00, 32'd0,
                  1, 0, 2'b00, 32'hF000, 32'hFF00, 5'd10, 0);
    vecs[8]  = mk(2'b10, 2'b00, 6'b100001, 32'hF0F0, 32'h0F0F, 32'd0, 5'd4, 5'd11, 2'b00, 2'b00, 32'd0,
                  1, 0, 2'b00, 32'hFFFF, 32'h0F0F, 5'd11, 0);
    vecs[9]  = mk(2'b10, 2'b00, 6'b100011, 32'hFFFF, 32'h00FF, 32'd0, 5'd4, 5'd12, 2'b00, 2'b00, 32'd0,
                  1, 0, 2'b00, 32'hFF00, 32'h00FF, 5'd12, 0);
    vecs[10] = mk(2'b10, 2'b00, 6'b101000, 32'd1, 32'h21, 32'd0, 5'd4, 5'd13, 2'b00, 2'b00, 32'd0,
                  1, 0, 2'b00, 32'd2, 32'h21, 5'd13, 0);
    vecs[11] = mk(2'b10, 2'b00, 6'b101001, 32'h8000_0000, 32'd4, 32'd0, 5'd4, 5'd14, 2'b00, 2'b00, 32'd0,
                  1, 0, 2'b00, 32'h0800_0000, 32'd4, 5'd14, 0);
    vecs[12] = mk(2'b10, 2'b00, 6'b101100, 32'd0, 32'd0, 32'd0, 5'd4, 5'd15, 2'b00, 2'b00, 32'd0,
                  1, 0, 2'b00, 32'hFFFF_FFFF, 32'd0, 5'd15, 0);
    vecs[13] = mk(2'b10, 2'b00, 6'b100010, 32'd6, 32'd2, 32'd0, 5'd4, 5'd16, 2'b11, 2'b11, 32'd0,
                  1, 0, 2'b00, 32'd8, 32'd2, 5'd16, 0);
    vecs[14] = mk(2'b10, 2'b00, 6'b100110, 32'd1, 32'd5, 32'd0, 5'd4, 5'd17, 2'b01, 2'b00, 32'd100,
                  1, 0, 2'b00, 32'd95, 32'd5, 5'd17, 0);
    vecs[15] = mk(2'b10, 2'b00, 6'b100010, 32'd5, 32'd77, 32'd0, 5'd4, 5'd18, 2'b00, 2'b10, 32'd0,
                  1, 0, 2'b00, 32'd100, 32'd95, 5'd18, 0);
    rel      = mk(2'b10, 2'b00, 6'b100010, 32'd0, 32'd1, 32'd0, 5'd4, 5'd4, 2'b10, 2'b00, 32'd0,
                  1, 0, 2'b00, 32'd101, 32'd1, 5'd4, 0);

    // Reset for two cycles with a live load presented on the inputs.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(vecs[0]);
    tick();
    tick();
    chk("reset", 74'd0);
    rst = 1'b0;

    // One-cycle latency table; each vector may forward the previous result.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Stall three cycles with changing inputs: outputs frozen.
    held = vecs[15].exp;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(vecs[2 * i]);
      tick();
      chk($sformatf("stall%0d", i), held);
    end

    // Release: forwarding from EX/MEM uses the held result (100 + 1).
    stall = 1'b0;
    drive(rel);
    tick();
    chk("stall_release_fwd", rel.exp);

    // Stall and flush together: bubble wins.
    stall = 1'b1; flush = 1'b1;
    drive(vecs[0]);
    tick();
    chk("stall_flush", 74'd0);

    // Reload, then reset while stalled.
    stall = 1'b0; flush = 1'b0;
    drive(vecs[0]);
    tick();
    chk("reload", vecs[0].exp);
    stall = 1'b1; rst = 1'b1;
    drive(vecs[2]);
    tick();
    chk("rst_in_stall", 74'd0);

    // First capture after reset release.
    rst = 1'b0; stall = 1'b0;
    drive(vecs[0]);
    tick();
    chk("post_rst_capture", vecs[0].exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port stall  in  1  hold EX/MEM register contents.
REQ-004 SHALL have port flush  in  1  load a bubble into the EX/MEM register.
REQ-005 SHALL have port ID_EX_wb  in  2  {regWrite, memToReg}.
REQ-006 SHALL have port ID_EX_m  in  2  {memRead, memWrite}.
REQ-007 SHALL have port ID_EX_ex  in  6  {regDst, aluSrc, aluOp[3:0]}.
REQ-008 SHALL have port ID_EX_readData1  in  32  register-file rs value.
REQ-009 SHALL have port ID_EX_readData2  in  32  register-file rt value.
REQ-010 SHALL have port ID_EX_imm  in  32  sign-extended immediate.
REQ-011 SHALL have port ID_EX_rt  in  5  rt index.
REQ-012 SHALL have port ID_EX_rd  in  5  rd index.
REQ-013 SHALL have port ForwardA  in  2  operand-A select from forwarding_unit.
REQ-014 SHALL have port ForwardB  in  2  operand-B select from forwarding_unit.
REQ-015 SHALL have port MEM_WB_writeData  in  32  write-back value from MEM/WB.
REQ-016 SHALL have port EX_MEM_regWrite  out  1  registered regWrite (feeds forwarding_unit).
REQ-017 SHALL have port EX_MEM_memToReg  out  1  registered memToReg.
REQ-018 SHALL have port EX_MEM_m  out  2  registered {memRead, memWrite}.
REQ-019 SHALL have port EX_MEM_aluResult  out  32  registered ALU result.
REQ-020 SHALL have port EX_MEM_writeData  out  32  registered store data.
REQ-021 SHALL have port EX_MEM_rd  out  5  registered destination index (feeds forwarding_unit).
REQ-022 SHALL have port EX_MEM_zero  out  1  registered ALU-result-is-zero flag.

Function
REQ-023 Operand A mux SHALL be: ForwardA 00 -> ID_EX_readData1, 10 -> EX_MEM_aluResult (current register output), 01 -> MEM_WB_writeData, 11 -> ID_EX_readData1.
REQ-024 Forwarded-B mux SHALL use the same encoding on ID_EX_readData2; its result is fwdB.
REQ-025 ALU operand B SHALL be ID_EX_imm when aluSrc=1, else fwdB; store data SHALL be fwdB regardless of aluSrc.
REQ-026 ALU SHALL implement aluOp: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed, result 1/0), 1000 SLL A by B[4:0], 1001 SRL A by B[4:0], 1100 NOR; any other code -> result 0.
REQ-027 ADD/SUB SHALL be 32-bit modulo (wrap-around, no overflow flag, no exception); SLT SHALL compare signed and be correct on overflowing differences (e.g. 0x80000000 < 0x7FFFFFFF -> 1).
REQ-028 Destination SHALL be ID_EX_rd when regDst=1, else ID_EX_rt.
REQ-029 When destination index is 0, registered EX_MEM_regWrite SHALL be 0 irrespective of ID_EX_wb.
REQ-030 EX/MEM register SHALL update once per clock with priority rst > flush > stall > load; latency ID/EX inputs -> EX_MEM outputs exactly 1 cycle.
REQ-031 flush=1 (rst=0) SHALL load all EX_MEM outputs with 0 next edge, regardless of stall.
REQ-032 stall=1 (rst=0, flush=0) SHALL hold all EX_MEM outputs unchanged; forwarding from EX/MEM during a stall SHALL use the held value.
REQ-033 EX_MEM_zero SHALL equal (ALU result == 0) computed in the same cycle as the captured result.
REQ-034 Block SHALL contain no combinational path from any input to any output.

Reset
REQ-035 rst=1 at a rising edge SHALL clear every output to 0 on that edge, overriding flush/stall/load, including mid-stream.
REQ-036 After rst deasserts, first capture SHALL occur on the next rising edge with stall=0.

Verification
REQ-037 rst 2 cycles -> all outputs 0; then ADD, rd1=5, rd2=7, Fwd 00/00, regDst=1, rd=3, wb=10 -> next edge aluResult=12, EX_MEM_rd=3, regWrite=1, zero=0.
REQ-038 Back-to-back: EX_MEM_aluResult=12, ForwardA=10, rd1=99, imm=1, aluSrc=1, ADD -> aluResult=13; ForwardB=01, MEM_WB_writeData=40, memWrite op -> writeData=40.
REQ-039 SUB 0x80000000-1 -> 0x7FFFFFFF; SLT 0x80000000 vs 0x7FFFFFFF -> 1; SUB 5-5 -> 0, zero=1; aluOp 1111 -> 0.
REQ-040 regDst=1, rd=0, wb=10 -> EX_MEM_regWrite=0, EX_MEM_rd=0.
REQ-041 stall=1 for 3 cycles with changing inputs -> outputs frozen; stall+flush same cycle -> all 0; rst asserted during stall -> all 0.
